// File: rtl/fuzzycpu_pkg.sv
// fuzzycpu_pkg: shared constants and typedefs for the fuzzycpu register path.
//   XLEN     - datapath width
//   AW       - register address width
//   NUM_REGS - number of architectural registers (2**AW, none hardwired)
package fuzzycpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NUM_REGS = 1 << AW;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_data_t;

endpackage

// File: rtl/operand_scoreboard.sv
// operand_scoreboard: one pending bit per register, set when an instruction
// that writes the register issues, cleared when its result is written back.
//   clk, rst            - clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr    - mark a register as having a write outstanding
//   clr_en, clr_addr    - retire the outstanding write of a register
//   look_a/b/c          - lookup addresses
//   pend_a/b/c          - pending bit of each lookup (pre-update state)
// When set and clear target the same register on one edge, the set wins:
// the newly issued instruction owns the register.
module operand_scoreboard
    import fuzzycpu_pkg::*;
#(
    parameter int unsigned AW = fuzzycpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] look_a,
    input  logic [AW-1:0] look_b,
    input  logic [AW-1:0] look_c,
    output logic          pend_a,
    output logic          pend_b,
    output logic          pend_c
);

    localparam int unsigned N = 1 << AW;

    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        // Applied after the clear so a same-register collision leaves it set.
        if (set_en) pending_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    assign pend_a = pending_q[look_a];
    assign pend_b = pending_q[look_b];
    assign pend_c = pending_q[look_c];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: operand fetch / writeback controller driving a 2R1W regfile.
// Issue requests (rs1, rs2, rd) are checked against a scoreboard of pending
// destinations (RAW on both sources, WAW on rd), operands are read from the
// regfile and registered into a valid/ready stage towards execute, and execute
// results are written back through the regfile write port.
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - issue handshake
//   in_rs1, in_rs2, in_rd, in_rd_en - decoded request fields
//   rf_addr_one/two, rf_data_one/two - regfile read ports (combinational)
//   rf_addr_write, rf_data_write, rf_we - regfile write port
//   wb_valid, wb_addr, wb_data    - execute result (always accepted)
//   op_valid/op_ready             - execute handshake
//   op_a, op_b, op_rd, op_rd_en   - registered operand pair and destination
// Build option: OPERAND_BYPASS_EN forwards wb_data to a matching source in
// the writeback cycle and lifts the matching hazard; undefined, hazards come
// from the scoreboard alone.
module operand_fetch #(
    parameter int unsigned XLEN = fuzzycpu_pkg::XLEN,
    parameter int unsigned AW   = fuzzycpu_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_rd_en,
    output logic [AW-1:0]   rf_addr_one,
    output logic [AW-1:0]   rf_addr_two,
    input  logic [XLEN-1:0] rf_data_one,
    input  logic [XLEN-1:0] rf_data_two,
    output logic [AW-1:0]   rf_addr_write,
    output logic [XLEN-1:0] rf_data_write,
    output logic            rf_we,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [AW-1:0]   op_rd,
    output logic            op_rd_en
);

    logic pend_rs1, pend_rs2, pend_rd;
    logic hit_rs1, hit_rs2, hit_rd;
    logic hazard;
    logic accept;

    logic            op_valid_q, op_valid_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [AW-1:0]   op_rd_q, op_rd_d;
    logic            op_rd_en_q, op_rd_en_d;

    operand_scoreboard #(.AW(AW)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept && in_rd_en),
        .set_addr (in_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .look_a   (in_rs1),
        .look_b   (in_rs2),
        .look_c   (in_rd),
        .pend_a   (pend_rs1),
        .pend_b   (pend_rs2),
        .pend_c   (pend_rd)
    );

`ifdef OPERAND_BYPASS_EN
    assign hit_rs1 = wb_valid && (wb_addr == in_rs1);
    assign hit_rs2 = wb_valid && (wb_addr == in_rs2);
    assign hit_rd  = wb_valid && (wb_addr == in_rd);
`else
    assign hit_rs1 = 1'b0;
    assign hit_rs2 = 1'b0;
    assign hit_rd  = 1'b0;
`endif

    assign hazard   = (pend_rs1 && !hit_rs1) ||
                      (pend_rs2 && !hit_rs2) ||
                      (in_rd_en && pend_rd && !hit_rd);
    assign in_ready = !hazard && (!op_valid_q || op_ready);
    assign accept   = in_valid && in_ready;

    assign rf_addr_one   = in_rs1;
    assign rf_addr_two   = in_rs2;
    assign rf_addr_write = wb_addr;
    assign rf_data_write = wb_data;
    assign rf_we         = wb_valid && !rst;

    always_comb begin
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_rd_d    = op_rd_q;
        op_rd_en_d = op_rd_en_q;
        if (accept) begin
            op_valid_d = 1'b1;
            op_a_d     = hit_rs1 ? wb_data : rf_data_one;
            op_b_d     = hit_rs2 ? wb_data : rf_data_two;
            op_rd_d    = in_rd;
            op_rd_en_d = in_rd_en;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_rd_q    <= '0;
            op_rd_en_q <= 1'b0;
        end else begin
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_rd_q    <= op_rd_d;
            op_rd_en_q <= op_rd_en_d;
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_rd    = op_rd_q;
    assign op_rd_en = op_rd_en_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand fetch and writeback controller: the initiator side of the `regfile` port set. It accepts decoded issue requests (rs1, rs2, rd), drives the regfile's two read ports and single write port, and holds a scoreboard of pending destination registers so an instruction never reads a stale operand. It presents fetched operand pairs to the execute stage through a registered valid/ready stage, and routes execute-stage results back into the regfile.

## Interface
- `XLEN`, 32, data width.
- `AW`, 5, register address width (2^AW registers; all general-purpose, no hardwired zero).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  issue request valid.
- `in_ready`  out  1  request accepted this cycle when `in_valid && in_ready`.
- `in_rs1`, `in_rs2`  in  AW  source register addresses.
- `in_rd`  in  AW  destination register.
- `in_rd_en`  in  1  instruction will write `in_rd`.
- `rf_addr_one`, `rf_addr_two`  out  AW  regfile read addresses (= `in_rs1`, `in_rs2`, combinational).
- `rf_data_one`, `rf_data_two`  in  XLEN  regfile read data (combinational read).
- `rf_addr_write`  out  AW  regfile write address (= `wb_addr`).
- `rf_data_write`  out  XLEN  regfile write data (= `wb_data`).
- `rf_we`  out  1  regfile write enable (= `wb_valid`, forced 0 during `rst`).
- `wb_valid`  in  1  execute result valid; always accepted, no backpressure.
- `wb_addr`  in  AW  result destination.
- `wb_data`  in  XLEN  result value.
- `op_valid`  out  1  operand pair valid.
- `op_ready`  in  1  execute stage accepts.
- `op_a`, `op_b`  out  XLEN  operand values.
- `op_rd`, `op_rd_en`  out  AW, 1  destination passed through.

## Operation
- Scoreboard: `pending[2^AW]`, bit set = write outstanding.
- Hazard: `pending[in_rs1] || pending[in_rs2] || (in_rd_en && pending[in_rd])` (RAW on both sources, WAW on destination). Sources checked regardless of use.
- `in_ready = !hazard && (!op_valid || op_ready)`.
- On accept: `op_a/op_b` <= selected read data, `op_rd/op_rd_en` <= request fields, `op_valid` <= 1; if `in_rd_en`, set `pending[in_rd]`.
- On `op_valid && op_ready` with no accept: `op_valid` <= 0; operand registers hold.
- On `wb_valid`: regfile write through `rf_*`; clear `pending[wb_addr]`. Writeback to a non-pending register still writes the regfile; scoreboard unchanged.
- Same-edge set and clear on one register: set wins (the new instruction owns it).
- `rs1 == rs2`, or `rs == rd` in one instruction: legal; the hazard check uses pre-update scoreboard.

## Timing
- Reset: `pending` = 0, `op_valid` = 0, `op_a` = `op_b` = 0, `op_rd` = 0, `op_rd_en` = 0. `in_ready` follows hazard logic (1 after reset when `op_valid` = 0).
- Accept at edge N -> `op_valid` high after edge N (1-cycle latency). Throughput 1 per cycle when hazard-free and `op_ready` held high.
- `op_*` stable while `op_valid && !op_ready`.
- `rst` mid-operation clears all outstanding `pending` bits and drops `op_valid` at the same edge. Writebacks for instructions issued before reset still write the regfile, but they do not affect the scoreboard.
- Without bypass: a consumer of a register written at edge N is accepted no earlier than the cycle after edge N.

## Configuration
- `OPERAND_BYPASS_EN` defined: when `wb_valid && wb_addr == in_rsX`, that source is not a hazard, and the operand is taken from `wb_data` instead of `rf_data_*`. A `wb_addr == in_rd` match also removes the WAW hazard. The consumer issues in the writeback cycle itself.
- Undefined: no forwarding. The hazard uses `pending` only, so the consumer stalls one extra cycle.

## Structure
- Shared package `fuzzycpu_pkg`: `XLEN`, `AW`, `NUM_REGS`, and the address/data typedefs.
- Sub-module `operand_scoreboard`: the pending vector with set/clear ports and three lookup outputs, including the set-wins rule.

## Test plan
- Reset, then issue rs1=1, rs2=2, rd=3, rd_en=1, with regfile r1=25, r2=35 -> next cycle `op_valid`=1, `op_a`=25, `op_b`=35, `op_rd`=3; `pending[3]`=1.
- RAW: issue rs1=3 while `pending[3]` is set -> `in_ready`=0. Apply wb addr=3, data=65 -> with bypass: accepted the same cycle, `op_a`=65. Without bypass: accepted the next cycle, `op_a`=65.
- Backpressure: hold `op_ready`=0 for 3 cycles with a second request pending -> `in_ready`=0 and `op_*` unchanged; release -> second pair appears 1 cycle later.
- WAW: rd=5 pending, then issue rd=5 -> stall until wb addr=5. Issue and wb on r5 at the same edge -> `pending[5]`=1 afterwards.
- Writeback to non-pending r7 with data 99 -> `rf_we`=1, `rf_addr_write`=7, `rf_data_write`=99; scoreboard unchanged.
- Assert `rst` with `pending[3]` set and `op_valid`=1 -> after the edge, `op_valid`=0 and a request reading r3 is accepted immediately.
